// File: rtl/arm_instr_encoder_pkg.sv
// Shared constants and types for the ARMv4 instruction encoder: family numbering,
// condition codes, field positions and the request/FIFO-entry layouts.
package arm_instr_encoder_pkg;

    localparam logic [3:0] FAM_DPI  = 4'd0;
    localparam logic [3:0] FAM_DPIS = 4'd1;
    localparam logic [3:0] FAM_DPRS = 4'd2;
    localparam logic [3:0] FAM_MUL  = 4'd3;
    localparam logic [3:0] FAM_MULL = 4'd4;
    localparam logic [3:0] FAM_MRS  = 4'd5;
    localparam logic [3:0] FAM_MSRI = 4'd6;
    localparam logic [3:0] FAM_MSRR = 4'd7;
    localparam logic [3:0] FAM_LSI  = 4'd8;
    localparam logic [3:0] FAM_LSR  = 4'd9;
    localparam logic [3:0] FAM_HLSI = 4'd10;
    localparam logic [3:0] FAM_HLSR = 4'd11;
    localparam logic [3:0] FAM_SWP  = 4'd12;
    localparam logic [3:0] FAM_LSM  = 4'd13;
    localparam logic [3:0] FAM_BR   = 4'd14;
    localparam logic [3:0] FAM_UND  = 4'd15;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam int COND_LSB  = 28;
    localparam int PUBWL_LSB = 20;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;
    localparam int RS_LSB    = 8;
    localparam int RM_LSB    = 0;

    localparam int DEPTH_DEF = 2;

    typedef struct packed {
        logic [3:0]  fam;
        logic [3:0]  cond;
        logic [3:0]  op;
        logic        s_bit;
        logic [4:0]  pubwl;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rm;
        logic [23:0] imm;
    } enc_req_t;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  fam;
        logic        err;
    } enc_ent_t;

endpackage

// File: rtl/arm_encode_fields.sv
// Combinational assembly of one 32-bit ARMv4 word plus illegal-combination flag
// from registered request fields; zero latency, no flow control of its own.
module arm_encode_fields
    import arm_instr_encoder_pkg::*;
(
    input  logic [3:0]  fam,
    input  logic [3:0]  cond,
    input  logic [3:0]  op,
    input  logic        s_bit,
    input  logic [4:0]  pubwl,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rm,
    input  logic [23:0] imm,
    output logic [31:0] word,
    output logic        err
);

    logic [27:0] body;

    always_comb begin
        body = '0;
        err  = 1'b0;
        case (fam)
            FAM_DPI:  body = {3'b001, op, s_bit, rn, rd, imm[11:0]};
            FAM_DPIS: body = {3'b000, op, s_bit, rn, rd, imm[11:7], imm[6:5], 1'b0, rm};
            FAM_DPRS: body = {3'b000, op, s_bit, rn, rd, rs, 1'b0, imm[6:5], 1'b1, rm};
            FAM_MUL: begin
                body = {6'b000000, op[0], s_bit, rd, rn, rs, 4'b1001, rm};
                err  = (rd == 4'hF) || (rm == 4'hF);
            end
            FAM_MULL: begin
                body = {5'b00001, op[1:0], s_bit, rn, rd, rs, 4'b1001, rm};
                err  = (rd == 4'hF) || (rm == 4'hF);
            end
            FAM_MRS:  body = {5'b00010, op[0], 2'b00, 4'hF, rd, 12'h000};
            FAM_MSRI: body = {5'b00110, op[0], 2'b10, rn, 4'hF, imm[11:0]};
            FAM_MSRR: body = {5'b00010, op[0], 2'b10, rn, 4'hF, 8'h00, rm};
            FAM_LSI:  body = {3'b010, pubwl, rn, rd, imm[11:0]};
            FAM_LSR:  body = {3'b011, pubwl, rn, rd, imm[11:7], imm[6:5], 1'b0, rm};
            // SH=00 in the halfword forms would decode as multiply/swap instead
            FAM_HLSI: begin
                body = {3'b000, pubwl[4], pubwl[3], 1'b1, pubwl[1], pubwl[0], rn, rd,
                        imm[7:4], 1'b1, op[1:0], 1'b1, imm[3:0]};
                err  = (op[1:0] == 2'b00);
            end
            FAM_HLSR: begin
                body = {3'b000, pubwl[4], pubwl[3], 1'b0, pubwl[1], pubwl[0], rn, rd,
                        4'b0000, 1'b1, op[1:0], 1'b1, rm};
                err  = (op[1:0] == 2'b00);
            end
            FAM_SWP:  body = {5'b00010, op[0], 2'b00, rn, rd, 4'b0000, 4'b1001, rm};
            FAM_LSM: begin
                body = {3'b100, pubwl, rn, imm[15:0]};
                err  = (imm[15:0] == 16'h0000);
            end
            FAM_BR:   body = {3'b101, op[0], imm[23:0]};
            FAM_UND:  body = {3'b011, imm[23:4], 1'b1, imm[3:0]};
            default:  body = '0;
        endcase
    end

    assign word = (32'(cond) << COND_LSB) | {4'h0, body};

endmodule

// File: rtl/arm_instr_encoder.sv
// ARMv4 instruction encoder: request register, combinational assembly, output FIFO.
// Accept-to-out_valid is two edges; in_ready drops once S1 plus FIFO occupancy reaches DEPTH.
module arm_instr_encoder
    import arm_instr_encoder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       fam,
    input  logic [3:0]       cond,
    input  logic [3:0]       op,
    input  logic             s_bit,
    input  logic [4:0]       pubwl,
    input  logic [3:0]       rn,
    input  logic [3:0]       rd,
    input  logic [3:0]       rs,
    input  logic [3:0]       rm,
    input  logic [23:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic [3:0]       out_fam,
    output logic             out_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    enc_req_t         s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    enc_ent_t         mem_q [DEPTH];
    enc_ent_t         mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] enc_count_q, enc_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic        accept, push, pop;
    logic [31:0] enc_word;
    logic        enc_err;

    // Ignores a same-cycle pop so the word already in S1 always has a FIFO slot
    assign in_ready  = rst_n && ((32'(count_q) + 32'(s1_valid_q)) < 32'(DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = s1_valid_q;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;

    arm_encode_fields u_fields (
        .fam   (s1_q.fam),
        .cond  (s1_q.cond),
        .op    (s1_q.op),
        .s_bit (s1_q.s_bit),
        .pubwl (s1_q.pubwl),
        .rn    (s1_q.rn),
        .rd    (s1_q.rd),
        .rs    (s1_q.rs),
        .rm    (s1_q.rm),
        .imm   (s1_q.imm),
        .word  (enc_word),
        .err   (enc_err)
    );

    always_comb begin
        s1_valid_d = accept;
        s1_d       = s1_q;
        if (accept) begin
            s1_d.fam   = fam;
            s1_d.cond  = cond;
            s1_d.op    = op;
            s1_d.s_bit = s_bit;
            s1_d.pubwl = pubwl;
            s1_d.rn    = rn;
            s1_d.rd    = rd;
            s1_d.rs    = rs;
            s1_d.rm    = rm;
            s1_d.imm   = imm;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{word: enc_word, fam: s1_q.fam, err: enc_err};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (pop) begin
            enc_count_d = enc_count_q + CNT_W'(1);
            if (mem_q[rd_ptr_q].err) begin
                err_count_d = err_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_word  = mem_q[rd_ptr_q].word;
    assign out_fam   = mem_q[rd_ptr_q].fam;
    assign out_err   = mem_q[rd_ptr_q].err;
    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Randomized and directed checks of arm_instr_encoder against a shift-and-OR
// reference encoder with a scoreboard of expected words.
module tb_arm_instr_encoder;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       fam, cond, op;
    logic             s_bit;
    logic [4:0]       pubwl;
    logic [3:0]       rn, rd, rs, rm;
    logic [23:0]      imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_word;
    logic [3:0]       out_fam;
    logic             out_err;
    logic [CNT_W-1:0] enc_count;
    logic [CNT_W-1:0] err_count;

    arm_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fam(fam), .cond(cond), .op(op), .s_bit(s_bit), .pubwl(pubwl),
        .rn(rn), .rd(rd), .rs(rs), .rm(rm), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_fam(out_fam), .out_err(out_err),
        .enc_count(enc_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  fam, cond, op;
        logic        s;
        logic [4:0]  pubwl;
        logic [3:0]  rn, rd, rs, rm;
        logic [23:0] imm;
    } req_t;

    typedef struct {
        logic [31:0] word;
        logic [3:0]  fam;
        logic        err;
    } exp_t;

    exp_t             sb[$];
    int               n_cmp = 0;
    int               n_bad = 0;
    int               n_acc = 0;
    logic [CNT_W-1:0] exp_enc = '0;
    logic [CNT_W-1:0] exp_err = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: place each field at its bit offset with plain arithmetic
    function automatic exp_t model(input req_t r);
        exp_t        e;
        int unsigned w, o, im, s, pw, n, d, t, m;
        o  = 32'(r.op);    im = 32'(r.imm);   s = 32'(r.s);   pw = 32'(r.pubwl);
        n  = 32'(r.rn);    d  = 32'(r.rd);    t = 32'(r.rs);  m  = 32'(r.rm);
        case (r.fam)
            4'd0:  w = (32'h1 << 25) | (o << 21) | (s << 20) | (n << 16) | (d << 12) | (im & 32'hFFF);
            4'd1:  w = (o << 21) | (s << 20) | (n << 16) | (d << 12) | (im & 32'hFE0) | m;
            4'd2:  w = (o << 21) | (s << 20) | (n << 16) | (d << 12) | (t << 8) | (im & 32'h60) | 32'h10 | m;
            4'd3:  w = ((o % 2) << 21) | (s << 20) | (d << 16) | (n << 12) | (t << 8) | 32'h90 | m;
            4'd4:  w = (32'h1 << 23) | ((o % 4) << 21) | (s << 20) | (n << 16) | (d << 12) | (t << 8) | 32'h90 | m;
            4'd5:  w = (32'h2 << 23) | ((o % 2) << 22) | (32'hF << 16) | (d << 12);
            4'd6:  w = (32'h6 << 23) | ((o % 2) << 22) | (32'h2 << 20) | (n << 16) | (32'hF << 12) | (im & 32'hFFF);
            4'd7:  w = (32'h2 << 23) | ((o % 2) << 22) | (32'h2 << 20) | (n << 16) | (32'hF << 12) | m;
            4'd8:  w = (32'h2 << 25) | (pw << 20) | (n << 16) | (d << 12) | (im & 32'hFFF);
            4'd9:  w = (32'h3 << 25) | (pw << 20) | (n << 16) | (d << 12) | (im & 32'hFE0) | m;
            4'd10: w = ((pw & 32'h1B) << 20) | (32'h1 << 22) | (n << 16) | (d << 12) | (((im >> 4) % 16) << 8)
                       | 32'h90 | ((o % 4) << 5) | (im % 16);
            4'd11: w = ((pw & 32'h1B) << 20) | (n << 16) | (d << 12) | 32'h90 | ((o % 4) << 5) | m;
            4'd12: w = (32'h2 << 23) | ((o % 2) << 22) | (n << 16) | (d << 12) | 32'h90 | m;
            4'd13: w = (32'h4 << 25) | (pw << 20) | (n << 16) | (im % 65536);
            4'd14: w = (32'h5 << 25) | ((o % 2) << 24) | im;
            default: w = (32'h3 << 25) | ((im >> 4) << 5) | 32'h10 | (im % 16);
        endcase
        e.word = w | (32'(r.cond) << 28);
        e.fam  = r.fam;
        e.err  = ((r.fam == 4'd10 || r.fam == 4'd11) && (o % 4) == 0)
              || (r.fam == 4'd13 && (im % 65536) == 0)
              || ((r.fam == 4'd3 || r.fam == 4'd4) && (d == 15 || m == 15));
        return e;
    endfunction

    function automatic req_t mk(input logic [3:0] f, input logic [3:0] c, input logic [3:0] o,
                                input logic [23:0] im);
        req_t r;
        r.fam = f; r.cond = c; r.op = o; r.s = 1'b1; r.pubwl = 5'h19;
        r.rn = 4'd3; r.rd = 4'd4; r.rs = 4'd5; r.rm = 4'd6; r.imm = im;
        return r;
    endfunction

    task automatic send(input req_t r);
        int budget = 0;
        fam = r.fam; cond = r.cond; op = r.op; s_bit = r.s; pubwl = r.pubwl;
        rn = r.rn; rd = r.rd; rs = r.rs; rm = r.rm; imm = r.imm;
        in_valid = 1'b1;
        #1;
        while (!in_ready && budget < 300) begin
            @(negedge clk); #1;
            budget++;
        end
        if (!in_ready) begin
            check_eq("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb.push_back(model(r));
            n_acc++;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk); #3;
        check_eq("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: checks every pop against the scoreboard, counters and head stability
    exp_t        mon_e;
    logic        hold_vld = 1'b0;
    logic [31:0] hold_word;
    logic [3:0]  hold_fam;
    always begin
        @(negedge clk); #2;
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                check_eq("hold_valid", 32'(out_valid), 32'd1);
                check_eq("hold_word", out_word, hold_word);
                check_eq("hold_fam", 32'(out_fam), 32'(hold_fam));
            end
            check_eq("enc_count", 32'(enc_count), 32'(exp_enc));
            check_eq("err_count", 32'(err_count), 32'(exp_err));
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("pop_unexpected", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("out_word", out_word, mon_e.word);
                    check_eq("out_fam", 32'(out_fam), 32'(mon_e.fam));
                    check_eq("out_err", 32'(out_err), 32'(mon_e.err));
                    exp_enc = exp_enc + 1'b1;
                    if (mon_e.err) exp_err = exp_err + 1'b1;
                end
            end
            hold_vld  = out_valid && !out_ready;
            hold_word = out_word;
            hold_fam  = out_fam;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic rand_done;
    req_t rq;
    int   base;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fam = '0; cond = '0; op = '0; s_bit = 1'b0; pubwl = '0;
        rn = '0; rd = '0; rs = '0; rm = '0; imm = '0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_word", out_word, 32'd0);
        check_eq("rst_out_fam", 32'(out_fam), 32'd0);
        check_eq("rst_out_err", 32'(out_err), 32'd0);
        check_eq("rst_enc_count", 32'(enc_count), 32'd0);
        check_eq("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed first word and its latency
        out_ready = 1'b1;
        rq = mk(4'd0, 4'hE, 4'd4, 24'h0000FF);
        rq.s = 1'b0; rq.rn = 4'd1; rq.rd = 4'd2;
        send(rq);
        #2;
        check_eq("lat_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk); #2;
        check_eq("lat_valid", 32'(out_valid), 32'd1);
        check_eq("dpi_word", out_word, 32'hE28120FF);
        check_eq("dpi_err", 32'(out_err), 32'd0);
        drain();
        check_eq("dpi_enc_count", 32'(enc_count), 32'd1);

        // Every family with cond=0 and legal fields
        for (int f = 0; f < 16; f++) begin
            send(mk(4'(f), 4'h0, 4'h5, 24'h00A5C3));
        end
        drain();

        // Illegal combinations still emit a word
        send(mk(4'd10, 4'h0, 4'h0, 24'h00A5C3));
        send(mk(4'd13, 4'h0, 4'h5, 24'h000000));
        drain();
        check_eq("err_count_two", 32'(err_count), 32'd2);

        // Backpressure: only DEPTH requests get in while the consumer stalls
        out_ready = 1'b0;
        base = n_acc;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    send(mk(4'(k + 8), 4'(k), 4'h3, 24'(32'h123450 + k)));
                end
            end
            begin
                repeat (6) @(negedge clk);
                #2;
                check_eq("bp_accepts", 32'(n_acc - base), 32'(DEPTH));
                check_eq("bp_in_ready", 32'(in_ready), 32'd0);
                check_eq("bp_out_valid", 32'(out_valid), 32'd1);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with a randomly stalling consumer
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    rq.fam = 4'($urandom_range(0, 15)); rq.cond = 4'($urandom);
                    rq.op = 4'($urandom); rq.s = 1'($urandom); rq.pubwl = 5'($urandom);
                    rq.rn = 4'($urandom); rq.rd = 4'($urandom); rq.rs = 4'($urandom);
                    rq.rm = 4'($urandom); rq.imm = 24'($urandom);
                    if ($urandom_range(0, 7) == 0) rq.imm[15:0] = 16'h0000;
                    send(rq);
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Branch with negative offset, held at the head
        out_ready = 1'b0;
        send(mk(4'd14, 4'hE, 4'd1, 24'hFFFFFE));
        begin
            int n = 0;
            #2;
            while (!out_valid && n < 20) begin
                @(negedge clk); #2;
                n++;
            end
        end
        check_eq("br_word", out_word, 32'hEBFFFFFE);
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send(mk(4'd8, 4'h1, 4'h2, 24'h000111));
        send(mk(4'd9, 4'h2, 4'h2, 24'h000222));
        rst_n = 1'b0;
        sb.delete();
        exp_enc = '0;
        exp_err = '0;
        #2;
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_enc_count", 32'(enc_count), 32'd0);
        check_eq("mid_rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rq = mk(4'd0, 4'hE, 4'd4, 24'h0000FF);
        rq.s = 1'b0; rq.rn = 4'd1; rq.rd = 4'd2;
        send(rq);
        drain();
        check_eq("post_rst_enc_count", 32'(enc_count), 32'd1);
        check_eq("post_rst_out_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
